// File: rtl/ec_codec_pkg.sv
// Shared SEC1 point-codec constants, FSM state type and format helpers.
// With EC_POINT_HYBRID_EN undefined, the hybrid form (6) is reported as unsupported.
package ec_codec_pkg;

    localparam logic [2:0] PC_COMPRESSED    = 3'd2;
    localparam logic [2:0] PC_UNCOMPRESSED  = 3'd4;
    localparam logic [2:0] PC_HYBRID        = 3'd6;
    localparam logic [7:0] PC_INFINITY_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        INF,
        HDR,
        BODY,
        ERR
    } enc_state_t;

    function automatic logic fmt_supported(input logic [2:0] fmt);
        logic ok;
        ok = (fmt == PC_COMPRESSED) || (fmt == PC_UNCOMPRESSED);
`ifdef EC_POINT_HYBRID_EN
        ok = ok || (fmt == PC_HYBRID);
`endif
        return ok;
    endfunction

    // Header octet carries the Y parity in bit 0 for the compressed and hybrid forms.
    function automatic logic [7:0] pc_header(input logic [2:0] fmt, input logic y_lsb);
        logic [7:0] hdr;
        hdr = 8'h00;
        if (fmt == PC_COMPRESSED) begin
            hdr = {7'b0000001, y_lsb};
        end else if (fmt == PC_UNCOMPRESSED) begin
            hdr = 8'h04;
        end
`ifdef EC_POINT_HYBRID_EN
        else if (fmt == PC_HYBRID) begin
            hdr = {7'b0000011, y_lsb};
        end
`endif
        return hdr;
    endfunction

endpackage

// File: rtl/ec_coord_shift_reg.sv
// Holds {X,Y} captured at frame start; each advance shifts left one byte.
// The top byte is presented straight from the register, so no output latency.
module ec_coord_shift_reg #(
    parameter int COORD_BYTES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [8*COORD_BYTES-1:0] x_i,
    input  logic [8*COORD_BYTES-1:0] y_i,
    input  logic                     advance_i,
    output logic [7:0]               byte_o
);

    localparam int W = 16 * COORD_BYTES;

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = {x_i, y_i};
        end else if (advance_i) begin
            sr_d = {sr_q[W-9:0], 8'h00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign byte_o = sr_q[W-1 -: 8];

endmodule

// File: rtl/ec_point_encoder.sv
// Streaming SEC1 point encoder: one byte per cycle, first byte registered one cycle after capture,
// holds out_data/out_last under out_ready backpressure. Hybrid form needs EC_POINT_HYBRID_EN.
module ec_point_encoder
    import ec_codec_pkg::*;
#(
    parameter int COORD_BYTES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*COORD_BYTES-1:0] in_x,
    input  logic [8*COORD_BYTES-1:0] in_y,
    input  logic                     in_inf,
    input  logic [2:0]               in_fmt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_last,
    output logic                     err,
    output logic                     busy
);

    localparam int                CNT_W  = $clog2(2*COORD_BYTES+1);
    localparam logic [CNT_W-1:0]  LEN_X  = CNT_W'(COORD_BYTES);
    localparam logic [CNT_W-1:0]  LEN_XY = CNT_W'(2*COORD_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    enc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hdr_q, hdr_d;
    logic             capture;
    logic             sr_advance;
    logic [7:0]       sr_byte;

    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);
    assign capture  = in_valid && in_ready;

    ec_coord_shift_reg #(
        .COORD_BYTES (COORD_BYTES)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load_i    (capture),
        .x_i       (in_x),
        .y_i       (in_y),
        .advance_i (sr_advance),
        .byte_o    (sr_byte)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        sr_advance = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    hdr_d = pc_header(in_fmt, in_y[0]);
                    cnt_d = (in_fmt == PC_COMPRESSED) ? LEN_X : LEN_XY;
                    if (in_inf) begin
                        state_d = INF;
                    end else if (fmt_supported(in_fmt)) begin
                        state_d = HDR;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            INF: begin
                out_valid = 1'b1;
                out_data  = PC_INFINITY_BYTE;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_q;
                if (out_ready) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                out_valid = 1'b1;
                out_data  = sr_byte;
                out_last  = (cnt_q == CNT_ONE);
                if (out_ready) begin
                    sr_advance = 1'b1;
                    cnt_d      = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hdr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
        end
    end

endmodule

// File: doc/ec_point_encoder.md
# ec_point_encoder

Streaming SEC1 point encoder that sits directly downstream of the EC scalar-multiplication core. It accepts one affine point (X, Y, infinity flag) per transaction and emits the octet-string public-key encoding (compressed, uncompressed or hybrid) one byte per cycle, MSB first. The byte stream feeds the key-export/serialization path.

## Interface
- `COORD_BYTES`, 32: coordinate size in bytes (32 for P-256, 48 for P-384, 66 for P-521).
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `in_valid` in 1: point available from the upstream core.
- `in_ready` out 1: encoder can accept a point.
- `in_x` in 8*COORD_BYTES: affine X, big-endian (byte 0 = bits [8*COORD_BYTES-1 -: 8]).
- `in_y` in 8*COORD_BYTES: affine Y, same ordering.
- `in_inf` in 1: point at infinity; X and Y are ignored.
- `in_fmt` in 3: conversion form. 2 = compressed, 4 = uncompressed, 6 = hybrid.
- `out_valid` out 1: `out_data` holds a valid byte.
- `out_ready` in 1: downstream accepts the byte.
- `out_data` out 8: encoded byte.
- `out_last` out 1: marks the final byte of the encoding.
- `err` out 1: one-cycle pulse when the format is rejected.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - **IDLE:** `in_ready`=1. On `in_valid` with `in_ready`, capture the point and decode the format:
    - `in_inf`=1 → INF.
    - Valid `in_fmt` → HDR.
    - Otherwise → ERR.
    - `in_inf` takes priority over `in_fmt`.
  - **INF:** emit 0x00 with `out_last`=1. On handshake → IDLE.
  - **HDR:** emit the header byte.
    - Compressed: 0x02 | Y[0].
    - Uncompressed: 0x04.
    - Hybrid: 0x06 | Y[0].
    - On handshake → BODY.
  - **BODY:** shift out the stored coordinate bytes, MSB first.
    - Compressed: X only, COORD_BYTES bytes.
    - Other formats: X then Y, 2*COORD_BYTES bytes.
    - `out_last` is asserted on the final body byte. After its handshake → IDLE.
  - **ERR:** `err`=1 for exactly one cycle, no bytes emitted → IDLE.
- Body-byte counter width: clog2(2*COORD_BYTES+1). It counts down from the body length to 1.
- Total frame length:
  - Compressed: 1+COORD_BYTES.
  - Uncompressed and hybrid: 1+2*COORD_BYTES.
  - Infinity: 1.
- Y parity is latched at capture. A later change on `in_y` does not affect the frame.
- Reset values: `in_ready`=0 while `rst` is high, then 1 in IDLE. `out_valid`=0, `out_data`=0x00, `out_last`=0, `err`=0, `busy`=0. The FSM resets to IDLE, the shift register and counter to 0.
- Reset mid-frame: the partial frame is abandoned. `out_valid` is 0 on the cycle after `rst`. No `out_last` or `err` is generated for the dropped frame.

## Timing
- Capture at edge t (`in_valid` and `in_ready`). The first byte is valid from cycle t+1, driven from registers.
- Throughput is one byte per cycle while `out_ready`=1. A P-256 uncompressed frame occupies 65 output cycles.
- While `out_valid` is high and `out_ready` is low, `out_data` and `out_last` hold stable.
- `out_valid` never drops without a handshake, except on reset.
- `in_ready` is low from capture until the cycle after the last handshake, so there is one idle cycle between frames.
- Invalid format: `err` pulses at t+1 and `in_ready` returns at t+2.
- A `out_ready` assertion with `out_valid` low is ignored.

## Configuration
- `EC_POINT_HYBRID_EN` defined: hybrid format 6 is supported, with header 0x06/0x07 followed by X and Y.
- Not defined: `in_fmt`=6 is treated as invalid and follows the ERR path. Hybrid header logic is compiled out.

## Structure
- Package `ec_codec_pkg` holds:
  - Format constants `PC_COMPRESSED`=3'd2, `PC_UNCOMPRESSED`=3'd4, `PC_HYBRID`=3'd6.
  - Header constant `PC_INFINITY_BYTE`=8'h00.
  - The FSM state enum `enc_state_t` (IDLE, INF, HDR, BODY, ERR).
- Sub-module `ec_coord_shift_reg`:
  - Loads the 16*COORD_BYTES-bit {X,Y}.
  - On each advance, shifts left 8 bits and presents the top byte.

## Test plan
- **Compressed P-256 G:** X=6B17D1F2…D898C296, Y=…37BF51F5 (odd), fmt 2, `out_ready`=1 → 33 bytes: 0x03, 0x6B, 0x17, …, 0x96. `out_last` on byte 33.
- **Uncompressed G, fmt 4:** → 65 bytes: 0x04, then X, then Y ending 0xF5. `out_last` only on byte 65. `in_ready` returns one cycle after the last byte.
- **Infinity:** `in_inf`=1, fmt 4 → single byte 0x00 with `out_last`=1.
- **Invalid format:** fmt 5 → `err` pulse at t+1, no `out_valid`, `in_ready`=1 at t+2.
- **Hybrid:** fmt 6 with Y even. With `EC_POINT_HYBRID_EN` → header 0x06 and 65 bytes. Without the macro → `err` pulse.
- **Backpressure and reset:**
  - Toggle `out_ready` randomly: every byte is delivered once, in order, and stays stable while stalled.
  - Assert `rst` after byte 10: `out_valid`=0 on the next cycle, and the next frame starts cleanly with its header byte.
